// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding and
// default frame parameters.
package uart_pkg;

    localparam int OVERSAMPLE      = 16;
    localparam int DBIT_DEFAULT    = 8;
    localparam int SB_TICK_DEFAULT = 16;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } rx_state_t;

    // Stop bits of 1.5 or 2 periods need one more bit in the sample counter.
    function automatic int s_cnt_width(input int sb_tick);
        return (sb_tick > OVERSAMPLE) ? 5 : 4;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and tick in, received byte and status out.
interface uart_rx_if;

    logic       rx;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx,
        output s_tick,
        input  dout,
        input  rx_done_tick,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        input  s_tick,
        output dout,
        output rx_done_tick,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; both flops reset
// to RESET_VAL so the output matches an idle line immediately after reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: async reset sits in the sensitivity list, and flops use <= so both
    // stages sample the pre-edge values and the chain really is two deep.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start-bit validation at mid-bit, LSB-first
// data capture, configurable data width and stop length, framing-error flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEFAULT,
    parameter int SB_TICK = SB_TICK_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);

    localparam int SCW = s_cnt_width(SB_TICK);

    localparam logic [SCW-1:0] CNT_MID       = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] CNT_BIT_LAST  = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] CNT_STOP_LAST = SCW'(SB_TICK - 1);
    localparam logic [2:0]     N_LAST        = 3'(DBIT - 1);

    logic rx_sync;

    rx_state_t      state_q, state_d;
    logic [SCW-1:0] s_cnt_q, s_cnt_d;
    logic [2:0]     n_cnt_q, n_cnt_d;
    logic [7:0]     b_q,     b_d;
    logic [7:0]     dout_q,  dout_d;
    logic           done_q,  done_d;
    logic           ferr_q,  ferr_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_sync)
    );

    always_comb begin
        // NOTE: every _d starts as its _q (done_d as 0) so no path leaves a
        // variable unassigned and no latch is inferred.
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_d     = b_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Start edge is taken on any clock, not just on a tick.
                if (!rx_sync) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end

            START: begin
                if (bus.s_tick) begin
                    if (s_cnt_q == CNT_MID) begin
                        if (!rx_sync) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SCW'(1);
                    end
                end
            end

            DATA: begin
                if (bus.s_tick) begin
                    if (s_cnt_q == CNT_BIT_LAST) begin
                        s_cnt_d = '0;
                        b_d     = {rx_sync, b_q[7:1]};
                        if (n_cnt_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 3'd1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SCW'(1);
                    end
                end
            end

            STOP: begin
                if (bus.s_tick) begin
                    if (s_cnt_q == CNT_STOP_LAST) begin
                        state_d = IDLE;
                        // Short frames land in the top of b; shift them down.
                        dout_d  = b_q >> (8 - DBIT);
                        ferr_d  = ~rx_sync;
                        done_d  = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + SCW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = ferr_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, 8: number of data bits per frame, range 5..8.
REQ-002 Parameter SB_TICK, 16: oversampling ticks for the stop bit, one of 16 (1 stop), 24 (1.5), 32 (2).
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 Port s_tick  input  1  one-clk-wide 16x-oversampling strobe from baud_gen.tick.
REQ-007 Port dout  output  8  last received byte, LSB-aligned; bits above DBIT-1 read 0.
REQ-008 Port rx_done_tick  output  1  one-clk pulse: dout and frame_err are updated.
REQ-009 Port frame_err  output  1  stop bit of last frame was sampled low.
REQ-010 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (flops reset to 1); the FSM SHALL see only rx_sync, 2 clk after rx.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; s_cnt is 4-bit, n_cnt is 3-bit, shift register b is 8-bit.
REQ-013 s_cnt, n_cnt and b SHALL change only on clk edges where s_tick=1, except the IDLE->START transition and its s_cnt clear.
REQ-014 IDLE: rx_sync=0 SHALL move to START with s_cnt=0, on any clk edge regardless of s_tick.
REQ-015 START on tick: if s_cnt=7 and rx_sync=0 -> DATA, s_cnt=0, n_cnt=0; if s_cnt=7 and rx_sync=1 -> IDLE (glitch reject, no output change); else s_cnt+1.
REQ-016 DATA on tick: if s_cnt=15 -> s_cnt=0, b={rx_sync,b[7:1]} (LSB first); then n_cnt=DBIT-1 -> STOP, else n_cnt+1; else s_cnt+1.
REQ-017 STOP on tick: if s_cnt=SB_TICK-1 -> IDLE, dout=b>>(8-DBIT), frame_err=~rx_sync, rx_done_tick=1 for the following clk only; else s_cnt+1 (s_cnt widened to 5 bits when SB_TICK>16).
REQ-018 rx_done_tick SHALL be registered: high in exactly the one clk cycle after the completing tick edge; never two consecutive cycles.
REQ-019 dout and frame_err SHALL hold their values between rx_done_tick pulses; a rejected glitch SHALL change neither.
REQ-020 Back-to-back frames: a start bit arriving while in STOP SHALL be detected on the first clk after returning to IDLE.
REQ-021 Continuous line-low (break) SHALL yield repeated frames of dout=0x00 with frame_err=1; no special break state.
REQ-022 s_tick asserted while in IDLE SHALL have no effect.

Reset
REQ-023 reset=1 SHALL immediately force state=IDLE, s_cnt=0, n_cnt=0, b=0, dout=0, rx_done_tick=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-024 reset mid-frame SHALL discard the partial byte; no rx_done_tick SHALL follow release of reset for that frame.
REQ-025 After reset release, the first frame SHALL be received correctly when its start edge is at least 2 clk after release.

Structure
REQ-026 Package uart_pkg SHALL hold the rx_state_t enum (IDLE, START, DATA, STOP), OVERSAMPLE=16 and default DBIT/SB_TICK constants.
REQ-027 The synchronizer SHALL be sub-module sync_2ff (clk, reset, d, q; reset value parameterized, 1 here); all else is flat in uart_rx.
REQ-028 Next-state/datapath logic SHALL be one combinational block plus one async-reset register block.

Verification
REQ-029 Bench: 100 MHz clk, baud_gen with dvsr=651 driving s_tick, 9600-baud serializer on rx, 8N1.
REQ-030 Send 0x55 -> one rx_done_tick pulse, dout=0x55, frame_err=0, busy low afterwards.
REQ-031 Send 0xA3 then 0x00 then 0xFF with no idle gap -> three pulses, dout 0xA3, 0x00, 0xFF in order, frame_err=0 each.
REQ-032 rx low for 4 s_tick periods then high -> no rx_done_tick, FSM back to IDLE, dout unchanged.
REQ-033 Send 0x3C with stop bit driven low -> dout=0x3C, frame_err=1; next good frame 0x81 -> frame_err=0.
REQ-034 Assert reset during data bit 4 of 0x96, release, send 0x5A -> exactly one pulse, dout=0x5A.
REQ-035 DBIT=7, SB_TICK=32, send 0x41 -> dout=0x41, frame_err=0, line idle before the next start accepted.
